// File: rtl/fp_mac_pkg.sv
// Shared definitions for the FP MAC addend-alignment datapath.
// Holds the width derivation helpers and the metadata flag bundle. The flags
// travel with each operand through both shift stages.
package fp_mac_pkg;

  // Significand width including the hidden bit.
  function automatic int unsigned mw_of(input int unsigned sig_width);
    return sig_width + 1;
  endfunction

  // Width of the fused-add alignment window.
  function automatic int unsigned aw_of(input int unsigned sig_width);
    return 3 * sig_width + 5;
  endfunction

  // Width of the shift count and of the exponent fields.
  function automatic int unsigned sw_of(input int unsigned ex_width);
    return ex_width + 2;
  endfunction

  // Bias that upstream exponent logic applies to the shift count.
  function automatic int unsigned shift_bias_of(input int unsigned sig_width);
    return sig_width + 4;
  endfunction

  localparam int unsigned SHIFT_BIAS = shift_bias_of(23);

  // Single-bit metadata forwarded alongside the aligned addend.
  typedef struct packed {
    logic sign_exp;
    logic prod_undf;
    logic eff_sub;
  } meta_flags_t;

endpackage

// File: rtl/align_shift_step.sv
// One registered right-shift step of the addend alignment.
// The step shifts by shamt*GRAN and ORs every dropped bit into the sticky bit.
// When ALIGN_STICKY_EN is not defined, the sticky input passes straight
// through. No dropped-bit reduction is built in that case.
module align_shift_step
  import fp_mac_pkg::*;
#(
  parameter int unsigned WIDTH  = 74,
  parameter int unsigned GRAN   = 8,
  parameter int unsigned SHW    = 7,
  parameter int unsigned META_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_window,
  input  logic              in_sticky,
  input  logic [META_W-1:0] in_meta,
  input  logic [SHW-1:0]    shamt,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_window,
  output logic              out_sticky,
  output logic [META_W-1:0] out_meta
);

  int unsigned      amt;
  logic [WIDTH-1:0] win_next;
  logic             st_next;

`ifdef ALIGN_STICKY_EN
  logic [2*WIDTH-1:0] ext;

  // Shift into a double-width vector so the dropped bits land in the low half.
  always_comb begin
    amt      = 32'(shamt) * GRAN;
    ext      = '0;
    win_next = '0;
    st_next  = in_sticky;
    if (amt >= WIDTH) begin
      st_next = in_sticky | (|in_window);
    end else begin
      ext      = {in_window, {WIDTH{1'b0}}} >> amt;
      win_next = ext[2*WIDTH-1:WIDTH];
      st_next  = in_sticky | (|ext[WIDTH-1:0]);
    end
  end
`else
  // Truncating shift. Bits shifted past bit 0 are discarded.
  always_comb begin
    amt      = 32'(shamt) * GRAN;
    win_next = in_window >> amt;
    st_next  = in_sticky;
  end
`endif

  // Stage register. It holds whenever the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_window <= '0;
      out_sticky <= 1'b0;
      out_meta   <= '0;
    end else if (adv) begin
      out_valid  <= in_valid;
      out_window <= win_next;
      out_sticky <= st_next;
      out_meta   <= in_meta;
    end
  end

endmodule

// File: rtl/fp_mac_align.sv
// Registered addend-alignment stage of the FP MAC datapath.
// A coarse byte-granular shift is followed by a fine bit-granular shift. The
// pipeline uses a global stall driven by out_ready.
// Optional feature macro: ALIGN_STICKY_EN (sticky accumulation of dropped bits).
module fp_mac_align
  import fp_mac_pkg::*;
#(
  parameter int unsigned sig_width = 23,
  parameter int unsigned ex_width  = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [sw_of(ex_width)-1:0]         shift,
  input  logic [sw_of(ex_width)-1:0]         sd,
  input  logic [sw_of(ex_width)-1:0]         max_exp,
  input  logic                               prod_undf,
  input  logic [ex_width-1:0]                Ec,
  input  logic [sig_width-1:0]               Mc,
  input  logic                               sc,
  input  logic                               sab,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [aw_of(sig_width)-1:0]        c_aligned,
  output logic                               sticky,
  output logic [sw_of(ex_width)-1:0]         max_exp_o,
  output logic                               sign_exp_o,
  output logic                               prod_undf_o,
  output logic                               eff_sub_o
);

  localparam int unsigned MW  = mw_of(sig_width);
  localparam int unsigned AW  = aw_of(sig_width);
  localparam int unsigned SW  = sw_of(ex_width);
  localparam int unsigned M1W = SW + 6;  // fine shift field + max_exp + flags
  localparam int unsigned M2W = SW + 3;  // max_exp + flags

  logic              adv;
  logic [MW-1:0]     mc;
  logic [AW-1:0]     win0;
  meta_flags_t       flags_in;
  meta_flags_t       flags_out;
  logic [M1W-1:0]    meta0;
  logic              s1_valid;
  logic [AW-1:0]     s1_window;
  logic              s1_sticky;
  logic [M1W-1:0]    s1_meta;
  logic [M2W-1:0]    s2_meta;
  logic              unused_sd;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign mc       = {(Ec != '0), Mc};
  assign win0     = {mc, {(AW - MW){1'b0}}};
  assign flags_in = '{sign_exp: sd[SW-1], prod_undf: prod_undf, eff_sub: sc ^ sab};
  // The fine shift field rides along with the metadata into stage 2.
  assign meta0    = {shift[2:0], max_exp, flags_in};
  assign unused_sd = ^sd[SW-2:0];

  align_shift_step #(
    .WIDTH (AW),
    .GRAN  (8),
    .SHW   (SW - 3),
    .META_W(M1W)
  ) u_coarse (
    .clk       (clk),
    .rst       (rst),
    .adv       (adv),
    .in_valid  (in_valid),
    .in_window (win0),
    .in_sticky (1'b0),
    .in_meta   (meta0),
    .shamt     (shift[SW-1:3]),
    .out_valid (s1_valid),
    .out_window(s1_window),
    .out_sticky(s1_sticky),
    .out_meta  (s1_meta)
  );

  align_shift_step #(
    .WIDTH (AW),
    .GRAN  (1),
    .SHW   (3),
    .META_W(M2W)
  ) u_fine (
    .clk       (clk),
    .rst       (rst),
    .adv       (adv),
    .in_valid  (s1_valid),
    .in_window (s1_window),
    .in_sticky (s1_sticky),
    .in_meta   (s1_meta[M2W-1:0]),
    .shamt     (s1_meta[M1W-1:M2W]),
    .out_valid (out_valid),
    .out_window(c_aligned),
    .out_sticky(sticky),
    .out_meta  (s2_meta)
  );

  assign {max_exp_o, flags_out} = s2_meta;
  assign sign_exp_o  = flags_out.sign_exp;
  assign prod_undf_o = flags_out.prod_undf;
  assign eff_sub_o   = flags_out.eff_sub;

endmodule
